// File: rtl/udma_regif_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// udma_regif_pkg : register offsets, CFG bit positions and APB FSM states
// Revision 1.0
// ----------------------------------------------------------------------------
package udma_regif_pkg;

  localparam logic [6:0] c_off_rx_saddr = 7'h00;
  localparam logic [6:0] c_off_rx_size  = 7'h04;
  localparam logic [6:0] c_off_rx_cfg   = 7'h08;
  localparam logic [6:0] c_off_tx_saddr = 7'h10;
  localparam logic [6:0] c_off_tx_size  = 7'h14;
  localparam logic [6:0] c_off_tx_cfg   = 7'h18;
  localparam logic [6:0] c_off_setup    = 7'h24;

  localparam int c_cfg_en      = 4;
  localparam int c_cfg_pending = 5;
  localparam int c_cfg_clr     = 6;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_HOLD   = 2'd2
  } apb_state_e;

  // CLR is self-clearing, so it always reads back as 0.
  function automatic logic [31:0] cfg_rdata(input logic busy, input logic pending);
    logic [31:0] v;
    v                = '0;
    v[c_cfg_en]      = busy;
    v[c_cfg_pending] = pending;
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/udma_chan_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// udma_chan_ctrl : per-channel busy/pending tracking with start/clr pulses
// Revision 1.0
// ----------------------------------------------------------------------------
module udma_chan_ctrl (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_wr,
  input  logic clr_wr,
  input  logic done_i,
  output logic busy,
  output logic pending,
  output logic start,
  output logic clr
);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      busy    <= 1'b0;
      pending <= 1'b0;
      start   <= 1'b0;
      clr     <= 1'b0;
    end else begin
      start <= 1'b0;
      clr   <= 1'b0;
      if (clr_wr) begin
        clr     <= 1'b1;
        busy    <= 1'b0;
        pending <= 1'b0;
      end else if (!busy) begin
        if (en_wr) begin
          start <= 1'b1;
          busy  <= 1'b1;
        end
      end else if (done_i) begin
        // An EN landing with done is queued and launched in the same step.
        if (pending || en_wr) begin
          start   <= 1'b1;
          pending <= 1'b0;
        end else begin
          busy <= 1'b0;
        end
      end else if (en_wr) begin
        pending <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/apb_udma_chan_regif.sv
`default_nettype none
// ----------------------------------------------------------------------------
// apb_udma_chan_regif : APB3 register window for one uDMA RX/TX peripheral
// Revision 1.0
// ----------------------------------------------------------------------------
module apb_udma_chan_regif
  import udma_regif_pkg::*;
#(
  parameter int WAIT_CYCLES = 0,
  parameter int SIZE_W      = 20
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [31:0]       paddr_i,
  input  logic [31:0]       pwdata_i,
  input  logic              pwrite_i,
  input  logic              psel_i,
  input  logic              penable_i,
  output logic [31:0]       prdata_o,
  output logic              pready_o,
  output logic              pslverr_o,
  output logic [31:0]       rx_saddr_o,
  output logic [31:0]       tx_saddr_o,
  output logic [SIZE_W-1:0] rx_size_o,
  output logic [SIZE_W-1:0] tx_size_o,
  output logic              rx_start_o,
  output logic              tx_start_o,
  output logic              rx_clr_o,
  output logic              tx_clr_o,
  input  logic              rx_done_i,
  input  logic              tx_done_i,
  output logic [31:0]       setup_o
);

  localparam logic [3:0] c_wait = 4'(WAIT_CYCLES);

  apb_state_e        r_state;
  apb_state_e        w_next;
  logic [3:0]        r_cnt;
  logic [31:0]       r_prdata;
  logic              r_err;
  logic              w_setup;
  logic              w_xfer;
  logic              w_pready;
  logic              w_wr;
  logic [6:0]        w_off;
  logic [31:0]       w_rdata;
  logic              w_dec_err;

  logic [31:0]       r_rx_saddr;
  logic [31:0]       r_tx_saddr;
  logic [SIZE_W-1:0] r_rx_size;
  logic [SIZE_W-1:0] r_tx_size;
  logic [31:0]       r_setup;

  logic              w_rx_busy, w_rx_pending, w_rx_en_wr, w_rx_clr_wr;
  logic              w_tx_busy, w_tx_pending, w_tx_en_wr, w_tx_clr_wr;

  logic              w_unused;
  assign w_unused = ^paddr_i[31:7];

  assign w_off = paddr_i[6:0];

  always_comb begin
    w_rdata   = '0;
    w_dec_err = 1'b0;
    case (w_off)
      c_off_rx_saddr: w_rdata = r_rx_saddr;
      c_off_rx_size:  w_rdata = 32'(r_rx_size);
      c_off_rx_cfg:   w_rdata = cfg_rdata(w_rx_busy, w_rx_pending);
      c_off_tx_saddr: w_rdata = r_tx_saddr;
      c_off_tx_size:  w_rdata = 32'(r_tx_size);
      c_off_tx_cfg:   w_rdata = cfg_rdata(w_tx_busy, w_tx_pending);
      c_off_setup:    w_rdata = r_setup;
      default:        w_dec_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next   = r_state;
    w_setup  = 1'b0;
    w_xfer   = 1'b0;
    w_pready = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (psel_i && !penable_i) begin
          w_next  = ST_ACCESS;
          w_setup = 1'b1;
        end
      end
      ST_ACCESS: begin
        w_pready = (r_cnt == 4'd0);
        if (!psel_i) begin
          w_next = ST_IDLE;
        end else if (penable_i && r_cnt == 4'd0) begin
          w_next = ST_HOLD;
          w_xfer = 1'b1;
        end
      end
      ST_HOLD: begin
        // Stays here while the initiator keeps psel/penable high: no re-commit.
        w_pready = 1'b1;
        if (psel_i && !penable_i) begin
          w_next  = ST_ACCESS;
          w_setup = 1'b1;
        end else if (!psel_i || !penable_i) begin
          w_next = ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_cnt    <= 4'd0;
      r_prdata <= '0;
      r_err    <= 1'b0;
    end else if (w_setup) begin
      r_cnt    <= c_wait;
      r_prdata <= w_rdata;
      r_err    <= w_dec_err;
    end else if (r_state == ST_ACCESS && psel_i && penable_i && r_cnt != 4'd0) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  assign pready_o  = w_pready;
  assign pslverr_o = r_err && (r_state != ST_IDLE);
  assign prdata_o  = r_prdata;

  assign w_wr = w_xfer && pwrite_i && !r_err;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_rx_saddr <= '0;
      r_tx_saddr <= '0;
      r_rx_size  <= '0;
      r_tx_size  <= '0;
      r_setup    <= '0;
    end else if (w_wr) begin
      case (w_off)
        c_off_rx_saddr: r_rx_saddr <= pwdata_i;
        c_off_rx_size:  r_rx_size  <= pwdata_i[SIZE_W-1:0];
        c_off_tx_saddr: r_tx_saddr <= pwdata_i;
        c_off_tx_size:  r_tx_size  <= pwdata_i[SIZE_W-1:0];
        c_off_setup:    r_setup    <= pwdata_i;
        default: ;
      endcase
    end
  end

  assign w_rx_clr_wr = w_wr && (w_off == c_off_rx_cfg) && pwdata_i[c_cfg_clr];
  assign w_rx_en_wr  = w_wr && (w_off == c_off_rx_cfg) && pwdata_i[c_cfg_en] && !pwdata_i[c_cfg_clr];
  assign w_tx_clr_wr = w_wr && (w_off == c_off_tx_cfg) && pwdata_i[c_cfg_clr];
  assign w_tx_en_wr  = w_wr && (w_off == c_off_tx_cfg) && pwdata_i[c_cfg_en] && !pwdata_i[c_cfg_clr];

  udma_chan_ctrl u_rx_ctrl (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .en_wr   (w_rx_en_wr),
    .clr_wr  (w_rx_clr_wr),
    .done_i  (rx_done_i),
    .busy    (w_rx_busy),
    .pending (w_rx_pending),
    .start   (rx_start_o),
    .clr     (rx_clr_o)
  );

  udma_chan_ctrl u_tx_ctrl (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .en_wr   (w_tx_en_wr),
    .clr_wr  (w_tx_clr_wr),
    .done_i  (tx_done_i),
    .busy    (w_tx_busy),
    .pending (w_tx_pending),
    .start   (tx_start_o),
    .clr     (tx_clr_o)
  );

  assign rx_saddr_o = r_rx_saddr;
  assign tx_saddr_o = r_tx_saddr;
  assign rx_size_o  = r_rx_size;
  assign tx_size_o  = r_tx_size;
  assign setup_o    = r_setup;

endmodule
`default_nettype wire

// File: tb/tb_apb_udma_chan_regif.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_apb_udma_chan_regif : directed vectors against two instances (0 and 3 wait states)
// Revision 1.0
// ----------------------------------------------------------------------------
module tb_apb_udma_chan_regif;

  localparam int SIZE_W = 20;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, pwrite, psel0, psel3, penable, rx_done, tx_done;
  logic [31:0] paddr, pwdata;

  logic [31:0]       prdata0, rx_saddr0, tx_saddr0, setup0;
  logic              pready0, pslverr0, rx_start0, tx_start0, rx_clr0, tx_clr0;
  logic [SIZE_W-1:0] rx_size0, tx_size0;

  logic [31:0]       prdata3, rx_saddr3, tx_saddr3, setup3;
  logic              pready3, pslverr3, rx_start3, tx_start3, rx_clr3, tx_clr3;
  logic [SIZE_W-1:0] rx_size3, tx_size3;

  apb_udma_chan_regif #(.WAIT_CYCLES(0), .SIZE_W(SIZE_W)) dut (
    .clk_i(clk), .rst_ni(rst_n), .paddr_i(paddr), .pwdata_i(pwdata), .pwrite_i(pwrite),
    .psel_i(psel0), .penable_i(penable), .prdata_o(prdata0), .pready_o(pready0),
    .pslverr_o(pslverr0), .rx_saddr_o(rx_saddr0), .tx_saddr_o(tx_saddr0),
    .rx_size_o(rx_size0), .tx_size_o(tx_size0), .rx_start_o(rx_start0),
    .tx_start_o(tx_start0), .rx_clr_o(rx_clr0), .tx_clr_o(tx_clr0),
    .rx_done_i(rx_done), .tx_done_i(tx_done), .setup_o(setup0)
  );

  apb_udma_chan_regif #(.WAIT_CYCLES(3), .SIZE_W(SIZE_W)) dut3 (
    .clk_i(clk), .rst_ni(rst_n), .paddr_i(paddr), .pwdata_i(pwdata), .pwrite_i(pwrite),
    .psel_i(psel3), .penable_i(penable), .prdata_o(prdata3), .pready_o(pready3),
    .pslverr_o(pslverr3), .rx_saddr_o(rx_saddr3), .tx_saddr_o(tx_saddr3),
    .rx_size_o(rx_size3), .tx_size_o(tx_size3), .rx_start_o(rx_start3),
    .tx_start_o(tx_start3), .rx_clr_o(rx_clr3), .tx_clr_o(tx_clr3),
    .rx_done_i(1'b0), .tx_done_i(1'b0), .setup_o(setup3)
  );

  int checks = 0;
  int errors = 0;

  // Pulse monitor: counts high cycles and back-to-back highs (pulses must be one cycle).
  int   n_tx_start = 0, n_rx_start = 0, n_rx_clr = 0, n_tx_clr = 0, n_long = 0;
  logic p_tx_start = 1'b0, p_rx_start = 1'b0, p_rx_clr = 1'b0, p_tx_clr = 1'b0;
  always @(posedge clk) begin
    if (tx_start0) n_tx_start <= n_tx_start + 1;
    if (rx_start0) n_rx_start <= n_rx_start + 1;
    if (rx_clr0)   n_rx_clr   <= n_rx_clr + 1;
    if (tx_clr0)   n_tx_clr   <= n_tx_clr + 1;
    if ((tx_start0 && p_tx_start) || (rx_start0 && p_rx_start) ||
        (rx_clr0 && p_rx_clr) || (tx_clr0 && p_tx_clr))
      n_long <= n_long + 1;
    p_tx_start <= tx_start0;
    p_rx_start <= rx_start0;
    p_rx_clr   <= rx_clr0;
    p_tx_clr   <= tx_clr0;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  // One APB transfer; hold = extra HOLD cycles with psel/penable kept high.
  task automatic apb(input bit t3, input logic [31:0] a, input logic [31:0] d, input bit wr,
                     input int hold, input bit done_at_commit,
                     output logic [31:0] rd, output logic err, output int lo);
    @(posedge clk); #1;
    paddr = a; pwdata = d; pwrite = wr; penable = 1'b0;
    if (t3) psel3 = 1'b1; else psel0 = 1'b1;
    @(posedge clk); #1;
    penable = 1'b1;
    lo = 0;
    while (!(t3 ? pready3 : pready0) && lo < 40) begin
      @(posedge clk); #1;
      lo++;
    end
    if (lo >= 40) begin
      checks++; errors++;
      $display("FAIL pready_timeout actual=low required=high");
    end
    rd  = t3 ? prdata3 : prdata0;
    err = t3 ? pslverr3 : pslverr0;
    if (done_at_commit) rx_done = 1'b1;
    @(posedge clk); #1;
    rx_done = 1'b0;
    repeat (hold) begin
      @(posedge clk); #1;
    end
    psel0 = 1'b0; psel3 = 1'b0; penable = 1'b0;
  endtask

  task automatic rd_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] rd; logic err; int lo;
    apb(1'b0, a, 32'h0, 1'b0, 0, 1'b0, rd, err, lo);
    chk(name, rd, exp);
  endtask

  task automatic wr0(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] rd; logic err; int lo;
    apb(1'b0, a, d, 1'b1, 1, 1'b0, rd, err, lo);
  endtask

  task automatic pulse_tx_done();
    @(posedge clk); #1; tx_done = 1'b1;
    @(posedge clk); #1; tx_done = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit          t3;
    logic [31:0] addr;
    logic [31:0] data;
    bit          wr;
    logic [31:0] exp_rd;
    bit          exp_err;
  } vec_t;

  vec_t vecs[16];

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd; logic err; int lo;
    int s_start, s_clr, s_rstart;

    vecs[0]  = '{0, 32'h10, 32'h1C00_0100, 1, 32'h0,         0};
    vecs[1]  = '{0, 32'h10, 32'h0,         0, 32'h1C00_0100, 0};
    vecs[2]  = '{0, 32'h04, 32'hFFFF_FFFF, 1, 32'h0,         0};
    vecs[3]  = '{0, 32'h04, 32'h0,         0, 32'h000F_FFFF, 0};
    vecs[4]  = '{0, 32'h24, 32'hA5A5_1234, 1, 32'h0,         0};
    vecs[5]  = '{0, 32'h24, 32'h0,         0, 32'hA5A5_1234, 0};
    vecs[6]  = '{0, 32'h00, 32'h1000_0000, 1, 32'h0,         0};
    vecs[7]  = '{0, 32'h00, 32'h0,         0, 32'h1000_0000, 0};
    vecs[8]  = '{0, 32'h14, 32'h0,         0, 32'h0,         0};
    vecs[9]  = '{0, 32'h0C, 32'h1234_5678, 1, 32'h0,         1};
    vecs[10] = '{0, 32'h0C, 32'h0,         0, 32'h0,         1};
    vecs[11] = '{0, 32'h26, 32'hDEAD_BEEF, 1, 32'h0,         1};
    vecs[12] = '{0, 32'h26, 32'h0,         0, 32'h0,         1};
    vecs[13] = '{1, 32'h10, 32'hCAFE_0000, 1, 32'h0,         0};
    vecs[14] = '{1, 32'h10, 32'h0,         0, 32'hCAFE_0000, 0};
    vecs[15] = '{1, 32'h0C, 32'h0,         0, 32'h0,         1};

    rst_n = 1'b0; psel0 = 1'b0; psel3 = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; rx_done = 1'b0; tx_done = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    chk("rst_pready", {31'b0, pready0}, 32'h0);
    chk("rst_pslverr", {31'b0, pslverr0}, 32'h0);
    chk("rst_prdata", prdata0, 32'h0);
    chk("rst_tx_saddr", tx_saddr0, 32'h0);
    chk("rst_setup", setup0, 32'h0);

    for (int i = 0; i < 16; i++) begin
      apb(vecs[i].t3, vecs[i].addr, vecs[i].data, vecs[i].wr, vecs[i].wr ? 1 : 0, 1'b0, rd, err, lo);
      chk($sformatf("vec%0d_pslverr", i), {31'b0, err}, {31'b0, vecs[i].exp_err});
      chk($sformatf("vec%0d_wait", i), lo, vecs[i].t3 ? 32'd3 : 32'd0);
      if (!vecs[i].wr || vecs[i].exp_err)
        chk($sformatf("vec%0d_prdata", i), rd, vecs[i].exp_rd);
    end

    chk("tx_saddr_out", tx_saddr0, 32'h1C00_0100);
    chk("rx_size_out", 32'(rx_size0), 32'h000F_FFFF);
    chk("setup_out", setup0, 32'hA5A5_1234);
    chk("rx_saddr_out", rx_saddr0, 32'h1000_0000);
    chk("tx_size_out", 32'(tx_size0), 32'h0);
    chk("dut3_tx_saddr", tx_saddr3, 32'hCAFE_0000);
    chk("idle_pslverr", {31'b0, pslverr0}, 32'h0);
    chk("idle_pready", {31'b0, pready0}, 32'h0);

    // TX channel: start, pending, done launches pending, final done idles.
    s_start = n_tx_start;
    wr0(32'h18, 32'h10);
    repeat (2) @(posedge clk);
    #1;
    chk("tx_start_first", n_tx_start - s_start, 32'd1);
    rd_chk("tx_cfg_busy", 32'h18, 32'h10);
    wr0(32'h18, 32'h10);
    rd_chk("tx_cfg_pending", 32'h18, 32'h30);
    chk("tx_no_start_pending", n_tx_start - s_start, 32'd1);
    pulse_tx_done();
    chk("tx_start_relaunch", n_tx_start - s_start, 32'd2);
    rd_chk("tx_cfg_after_done1", 32'h18, 32'h10);
    pulse_tx_done();
    rd_chk("tx_cfg_after_done2", 32'h18, 32'h00);
    chk("tx_no_extra_start", n_tx_start - s_start, 32'd2);

    // RX: busy+pending, then CLR commits alongside done.
    wr0(32'h08, 32'h10);
    wr0(32'h08, 32'h10);
    rd_chk("rx_cfg_pending", 32'h08, 32'h30);
    s_rstart = n_rx_start;
    s_clr    = n_rx_clr;
    apb(1'b0, 32'h08, 32'h40, 1'b1, 0, 1'b1, rd, err, lo);
    repeat (2) @(posedge clk);
    #1;
    chk("rx_clr_pulse", n_rx_clr - s_clr, 32'd1);
    chk("rx_no_start_on_clr", n_rx_start - s_rstart, 32'd0);
    rd_chk("rx_cfg_after_clr", 32'h08, 32'h00);
    chk("pulse_width", n_long, 32'd0);
    chk("tx_clr_quiet", n_tx_clr, 32'd0);

    // Reset mid-ACCESS with TX busy.
    wr0(32'h18, 32'h10);
    rd_chk("tx_busy_before_rst", 32'h18, 32'h10);
    @(posedge clk); #1;
    paddr = 32'h18; pwrite = 1'b0; psel0 = 1'b1; penable = 1'b0;
    @(posedge clk); #1;
    penable = 1'b1; rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1; psel0 = 1'b0; penable = 1'b0;
    chk("rst2_pready", {31'b0, pready0}, 32'h0);
    chk("rst2_pslverr", {31'b0, pslverr0}, 32'h0);
    chk("rst2_prdata", prdata0, 32'h0);
    chk("rst2_tx_saddr", tx_saddr0, 32'h0);
    chk("rst2_rx_size", 32'(rx_size0), 32'h0);
    chk("rst2_setup", setup0, 32'h0);
    chk("rst2_start", {30'b0, tx_start0, rx_start0}, 32'h0);
    rd_chk("rst2_tx_cfg", 32'h18, 32'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/apb_udma_chan_regif.md
Name: apb_udma_chan_regif

Overview:
- APB3 responder (slave) exposing one uDMA peripheral register window: RX/TX channel start address, size and config, plus a SETUP register.
- Sits behind the peripheral APB crossbar at PERIPH_ID_OFFSET + n*0x80.
- Converts CFG writes into channel start pulses and tracks per-channel busy/pending state against done pulses from the channel engines.

Parameters:
- WAIT_CYCLES, 0, extra ACCESS cycles with pready low before completion (0..15).
- SIZE_W, 20, width of the RX_SIZE/TX_SIZE fields.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  synchronous active-low reset
- paddr_i  in  32  APB address; only [6:0] decoded
- pwdata_i  in  32  write data
- pwrite_i  in  1  1=write
- psel_i  in  1  select
- penable_i  in  1  enable
- prdata_o  out  32  read data
- pready_o  out  1  ready
- pslverr_o  out  1  error
- rx_saddr_o, tx_saddr_o  out  32  channel start address
- rx_size_o, tx_size_o  out  SIZE_W  channel transfer size
- rx_start_o, tx_start_o  out  1  one-cycle channel start pulse
- rx_clr_o, tx_clr_o  out  1  one-cycle abort pulse
- rx_done_i, tx_done_i  in  1  channel finished (one-cycle pulse)
- setup_o  out  32  SETUP register contents

Behaviour:
- Reset: one clock, synchronous, active-low (rst_ni sampled on clk_i rising edge). All registers and outputs are 0, the FSM is IDLE, and busy/pending are cleared.
- Register map (paddr[6:0]):
  - 0x00 RX_SADDR rw32
  - 0x04 RX_SIZE rw[SIZE_W-1:0]
  - 0x08 RX_CFG
  - 0x10 TX_SADDR
  - 0x14 TX_SIZE
  - 0x18 TX_CFG
  - 0x24 SETUP rw32
- CFG fields: bit4 EN (w1 = start request; reads busy), bit5 PENDING (ro), bit6 CLR (w1, self-clearing, reads 0). Other bits read 0.
- Unmapped offset or paddr[1:0]!=0: access completes normally with pslverr_o=1, prdata_o=0, no state change.
- FSM IDLE/ACCESS/HOLD:
  - IDLE: on psel_i & ~penable_i, go to ACCESS. Load wait counter = WAIT_CYCLES. Snapshot decoded read data and error into prdata_o/pslverr_o.
  - ACCESS: pready_o = (cnt==0). The counter decrements while psel_i & penable_i. With WAIT_CYCLES=0, pready_o is already 1 in the cycle penable_i first rises. On the edge where psel_i & penable_i & pready_o, commit the write (if pwrite_i and no error) and go to HOLD. If psel_i drops in ACCESS, return to IDLE with no commit.
  - HOLD: pready_o=1, and prdata_o/pslverr_o hold their values. No second commit while psel_i & penable_i stay high; the initiator may hold them one or more extra cycles. On ~penable_i: go to ACCESS if psel_i (new setup), otherwise IDLE.
  - pready_o/pslverr_o are 0 in IDLE. prdata_o keeps its last value until the next setup.
- Channel control (per channel, identical):
  - EN write with busy=0: start_o pulses in the cycle after commit; busy=1.
  - EN write with busy=1: pending=1. A second EN while pending is dropped.
  - done_i with pending=1: start_o pulses next cycle; pending=0; busy stays 1.
  - done_i with pending=0: busy=0.
  - EN commit in the same cycle as done_i with busy=1: treated as pending, then launched; start_o pulses next cycle and busy stays 1.
  - CLR commit: clr_o pulses next cycle; busy=0, pending=0. CLR wins over simultaneous EN and done_i. Writing EN and CLR together = CLR only.
  - done_i with busy=0: ignored.
- SADDR/SIZE are writable at any time. Outputs drive the registers directly; the engine latches them on start_o. SIZE writes truncate to SIZE_W, and upper read bits are 0.

Decomposition:
- Shared package (udma_regif_pkg):
  - register offset constants
  - CFG bit-index constants (EN=4, PENDING=5, CLR=6)
  - APB FSM state enum
- One sub-module, udma_chan_ctrl, instantiated twice (RX, TX): busy/pending/start/clr logic. Inputs are en_wr/clr_wr strobes and done_i; outputs are busy, pending, start, clr.

Test Plan:
- Write 0x1C00_0100 to 0x10, then read 0x10 (bench initiator sequence, WAIT_CYCLES=0) -> tx_saddr_o=0x1C00_0100. Read data 0x1C00_0100, pslverr_o=0, exactly one commit despite penable held an extra cycle.
- Write 0xFFFF_FFFF to 0x04 (SIZE_W=20) -> rx_size_o=0xFFFFF; read returns 0x000F_FFFF.
- Write 0x10 to 0x18 -> tx_start_o one-cycle pulse. Read 0x18 returns 0x10. A second 0x10 write returns 0x30. Pulse tx_done_i -> tx_start_o pulses again and the read returns 0x10. Pulse tx_done_i again -> read returns 0x00.
- rx busy+pending, then write 0x40 to 0x08 in the same cycle rx_done_i pulses -> rx_clr_o pulses, no rx_start_o, read 0x08 returns 0x00.
- Access 0x0C and 0x26 -> pslverr_o=1 with pready_o, prdata_o=0, all outputs unchanged. WAIT_CYCLES=3: pready_o low exactly 3 ACCESS cycles.
- Assert rst_ni=0 for one cycle mid-ACCESS with tx busy -> next cycle all outputs 0, FSM IDLE, read 0x18 returns 0.
